// File: rtl/decim_seq_pkg.sv
// Shared types and constants for the decimation-core control sequencer.
package decim_seq_pkg;

  localparam int unsigned DECIM_CTRL_W = 8;

  localparam logic [1:0] ST_RST_HOLD = 2'd0;
  localparam logic [1:0] ST_SETTLE   = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;

  typedef enum logic [1:0] {
    StRstHold = ST_RST_HOLD,
    StSettle  = ST_SETTLE,
    StRun     = ST_RUN
  } seq_state_e;

  // Width needed to hold 0..max_val, never narrower than one bit.
  function automatic int unsigned cnt_w(int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/decim_seq_dncnt.sv
// Loadable down-counter that stops at zero; zero_o flags the final counted cycle.
module decim_seq_dncnt #(
  parameter int unsigned      Width    = 8,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= ResetVal;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/decim_ctrl_sequencer.sv
// Reconfiguration sequencer for the decimation core: reset hold, settle, run.
// Optional forwarded-valid counter enabled by DECIM_SEQ_VALID_CNT_EN.
module decim_ctrl_sequencer
  import decim_seq_pkg::*;
#(
  parameter int unsigned RstCycles     = 16,
  parameter int unsigned SettleValids  = 8,
  parameter int unsigned TimeoutCycles = 65535
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cfg_wr_i,
  input  logic [DECIM_CTRL_W-1:0] cfg_decim_i,
  input  logic                    cfg_test_i,
  output logic                    dec_rst_o,
  output logic [DECIM_CTRL_W-1:0] decim_ctrl_o,
  output logic                    test_ctrl_o,
  input  logic                    dec_valid_i,
  output logic                    valid_o,
  output logic                    run_o,
  output logic                    busy_o,
  output logic                    timeout_o
`ifdef DECIM_SEQ_VALID_CNT_EN
  ,
  output logic [31:0]             valid_cnt_o
`endif
);

  localparam int unsigned RstW = cnt_w(RstCycles);
  localparam int unsigned TmoW = cnt_w(TimeoutCycles);
  localparam int unsigned SetW = cnt_w(SettleValids);

  // Counters are loaded with N-1 so zero_o marks the Nth (last) cycle.
  localparam logic [RstW-1:0] RstLoad    = RstW'(RstCycles - 1);
  localparam logic [TmoW-1:0] TmoLoad    = TmoW'(TimeoutCycles - 1);
  localparam logic [SetW-1:0] SettleLast = SetW'((SettleValids == 0) ? 0 : SettleValids - 1);

  seq_state_e state_q, state_d;
  logic       run_q;

  logic [DECIM_CTRL_W-1:0] decim_q, decim_d;
  logic                    test_q, test_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [DECIM_CTRL_W-1:0] pend_decim_q, pend_decim_d;
  logic                    pend_test_q, pend_test_d;
  logic                    timeout_q, timeout_d;
  logic [SetW-1:0]         settle_q, settle_d;
  logic                    valid_q, valid_d;

  logic rst_load, rst_zero;
  logic tmo_load, tmo_zero;
  logic settle_done;

  decim_seq_dncnt #(
    .Width    (RstW),
    .ResetVal (RstLoad)
  ) u_rst_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (rst_load),
    .load_val_i (RstLoad),
    .en_i       (state_q == StRstHold),
    .zero_o     (rst_zero)
  );

  decim_seq_dncnt #(
    .Width    (TmoW),
    .ResetVal (TmoLoad)
  ) u_tmo_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmo_load),
    .load_val_i (TmoLoad),
    .en_i       (state_q == StSettle),
    .zero_o     (tmo_zero)
  );

  assign settle_done = (SettleValids == 0) || (dec_valid_i && (settle_q == SettleLast));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StRstHold;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= (state_d == StRun);
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d      = state_q;
    decim_d      = decim_q;
    test_d       = test_q;
    pend_vld_d   = pend_vld_q;
    pend_decim_d = pend_decim_q;
    pend_test_d  = pend_test_q;
    timeout_d    = timeout_q;
    settle_d     = settle_q;
    rst_load     = 1'b0;
    tmo_load     = 1'b0;

    if (cfg_wr_i && (state_q != StRun)) begin
      pend_vld_d   = 1'b1;
      pend_decim_d = cfg_decim_i;
      pend_test_d  = cfg_test_i;
    end

    unique case (state_q)
      StRstHold: begin
        if (rst_zero) begin
          state_d  = StSettle;
          tmo_load = 1'b1;
          settle_d = '0;
        end
      end
      StSettle: begin
        if (dec_valid_i) begin
          settle_d = settle_q + SetW'(1);
        end
        if (settle_done || tmo_zero) begin
          // A write on the exit cycle is the newest word, so it beats pending.
          if (cfg_wr_i || pend_vld_q) begin
            state_d    = StRstHold;
            rst_load   = 1'b1;
            pend_vld_d = 1'b0;
            decim_d    = cfg_wr_i ? cfg_decim_i : pend_decim_q;
            test_d     = cfg_wr_i ? cfg_test_i : pend_test_q;
            timeout_d  = !settle_done;
          end else begin
            state_d = StRun;
            if (!settle_done) begin
              timeout_d = 1'b1;
            end
          end
        end
      end
      StRun: begin
        if (cfg_wr_i) begin
          state_d   = StRstHold;
          rst_load  = 1'b1;
          decim_d   = cfg_decim_i;
          test_d    = cfg_test_i;
          timeout_d = 1'b0;
        end
      end
      default: begin
        state_d  = StRstHold;
        rst_load = 1'b1;
      end
    endcase

    valid_d = dec_valid_i && (state_q == StRun);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      decim_q      <= '0;
      test_q       <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_decim_q <= '0;
      pend_test_q  <= 1'b0;
      timeout_q    <= 1'b0;
      settle_q     <= '0;
      valid_q      <= 1'b0;
    end else begin
      decim_q      <= decim_d;
      test_q       <= test_d;
      pend_vld_q   <= pend_vld_d;
      pend_decim_q <= pend_decim_d;
      pend_test_q  <= pend_test_d;
      timeout_q    <= timeout_d;
      settle_q     <= settle_d;
      valid_q      <= valid_d;
    end
  end

  // Outputs.
  always_comb begin
    dec_rst_o    = (state_q == StRstHold);
    run_o        = run_q;
    busy_o       = ~run_q;
    decim_ctrl_o = decim_q;
    test_ctrl_o  = test_q;
    valid_o      = valid_q;
    timeout_o    = timeout_q;
  end

`ifdef DECIM_SEQ_VALID_CNT_EN
  logic [31:0] valid_cnt_q, valid_cnt_d;

  // Held at zero for all of RST_HOLD so a trailing forwarded valid is not counted.
  always_comb begin
    valid_cnt_d = valid_cnt_q + {31'b0, valid_q};
    if (state_d == StRstHold) begin
      valid_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_cnt_q <= '0;
    end else begin
      valid_cnt_q <= valid_cnt_d;
    end
  end

  assign valid_cnt_o = valid_cnt_q;
`endif

endmodule
